msu_audio_fill: RTL and testbench

- Streaming feeder that sits directly upstream of the audio DAC stage and fills its 2 KiB sample buffer through the buffer's byte write port.
- Takes a byte stream (e.g. from SD DMA), primes the whole buffer, then releases the DAC.
- Refills each 1 KiB half as soon as the DAC's half-indicator shows playback has moved to the other half.
- Detects and flags underruns.

---
 rtl/msu_audio_fill_if.sv | 23 ++
 rtl/msu_audio_fill.sv | 155 +++++++++++++++
 tb/tb_msu_audio_fill.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/msu_audio_fill_if.sv
// Byte stream in / DAC buffer write port out, bundled for msu_audio_fill.
interface msu_audio_fill_if #(
    parameter int BUF_AW = 11
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [BUF_AW-1:0] pgm_address;
    logic [7:0]        pgm_data;
    logic              pgm_we_n;

    // upstream source / buffer observer side
    modport master (
        output in_data, in_valid,
        input  in_ready, pgm_address, pgm_data, pgm_we_n
    );

    // feeder side
    modport slave (
        input  in_data, in_valid,
        output in_ready, pgm_address, pgm_data, pgm_we_n
    );
endinterface

// File: rtl/msu_audio_fill.sv
// Streaming feeder for the audio DAC sample buffer: primes the whole buffer,
// then refills each half as the DAC moves off it, flagging late refills.
module msu_audio_fill #(
    parameter int BUF_AW      = 11,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clkin,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dac_status,
    msu_audio_fill_if.slave  bus,
    output logic             dac_reset,
    output logic             dac_play,
    output logic             fill_req,
    output logic             underrun,
    output logic             busy
);
    localparam int HALF_AW = BUF_AW - 1;

    typedef enum logic [1:0] {IDLE, PRIME, PLAY_WAIT, FILL} state_t;

    state_t                 state_q, state_d;
    logic [BUF_AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   st_prev_q, st_prev_d;
    logic                   we_n_q, we_n_d;
    logic [BUF_AW-1:0]      addr_q, addr_d;
    logic [7:0]             data_q, data_d;
    logic                   dac_reset_q, dac_reset_d;
    logic                   dac_play_q, dac_play_d;
    logic                   fill_req_q, fill_req_d;
    logic                   underrun_q, underrun_d;

    logic                   st, st_edge, hs;
    logic [BUF_AW-1:0]      realign;

    // st is the synchronised DAC half; st_prev is one cycle older, so an edge
    // is seen only after the new level has fully crossed the synchroniser.
    assign st      = sync_q[SYNC_STAGES-1];
    assign st_edge = st ^ st_prev_q;
    // DAC now plays half st, so the half to refill is the other one.
    assign realign = {~st, {HALF_AW{1'b0}}};

    assign bus.in_ready    = (state_q == PRIME) || (state_q == FILL);
    assign hs              = bus.in_valid && bus.in_ready;
    assign bus.pgm_we_n    = we_n_q;
    assign bus.pgm_address = addr_q;
    assign bus.pgm_data    = data_q;
    assign dac_reset       = dac_reset_q;
    assign dac_play        = dac_play_q;
    assign fill_req        = fill_req_q;
    assign underrun        = underrun_q;
    assign busy            = (state_q != IDLE);

    // Next-state: write path, pointer, FSM, with stop then start overriding.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        sync_d      = {sync_q[SYNC_STAGES-2:0], dac_status};
        st_prev_d   = st;
        we_n_d      = 1'b1;
        addr_d      = addr_q;
        data_d      = data_q;
        dac_reset_d = dac_reset_q;
        dac_play_d  = dac_play_q;
        fill_req_d  = 1'b0;
        underrun_d  = underrun_q;

        // Every accepted byte lands one cycle later at the pre-increment pointer.
        if (hs) begin
            we_n_d   = 1'b0;
            addr_d   = wr_ptr_q;
            data_d   = bus.in_data;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case (state_q)
            IDLE: ;
            PRIME: begin
                // Half-indicator edges are meaningless until the DAC runs.
                if (hs && (wr_ptr_q == {BUF_AW{1'b1}})) begin
                    state_d     = PLAY_WAIT;
                    dac_reset_d = 1'b0;
                    dac_play_d  = 1'b1;
                end
            end
            PLAY_WAIT: begin
                if (st_edge) begin
                    wr_ptr_d   = realign;
                    fill_req_d = 1'b1;
                    state_d    = FILL;
                end
            end
            FILL: begin
                // DAC reached the next boundary first: drop the rest of this
                // half and restart on the half it just vacated. A coincident
                // byte is still written at the old address.
                if (st_edge) begin
                    underrun_d = 1'b1;
                    wr_ptr_d   = realign;
                    fill_req_d = 1'b1;
                end else if (hs && (&wr_ptr_q[HALF_AW-1:0])) begin
                    state_d = PLAY_WAIT;
                end
            end
            default: state_d = IDLE;
        endcase

        if (stop) begin
            state_d     = IDLE;
            dac_play_d  = 1'b0;
            dac_reset_d = 1'b1;
            fill_req_d  = 1'b0;
        end

        if (start) begin
            state_d     = PRIME;
            wr_ptr_d    = '0;
            underrun_d  = 1'b0;
            dac_play_d  = 1'b0;
            dac_reset_d = 1'b1;
            fill_req_d  = 1'b0;
        end
    end

    // State registers; reset aborts everything including a pending write.
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            sync_q      <= '0;
            st_prev_q   <= 1'b0;
            we_n_q      <= 1'b1;
            addr_q      <= '0;
            data_q      <= '0;
            dac_reset_q <= 1'b1;
            dac_play_q  <= 1'b0;
            fill_req_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            sync_q      <= sync_d;
            st_prev_q   <= st_prev_d;
            we_n_q      <= we_n_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            dac_reset_q <= dac_reset_d;
            dac_play_q  <= dac_play_d;
            fill_req_q  <= fill_req_d;
            underrun_q  <= underrun_d;
        end
    end
endmodule

// File: tb/tb_msu_audio_fill.sv
// Directed bench for msu_audio_fill: prime, refills, underrun, gaps,
// stop/restart and asynchronous reset.
module tb_msu_audio_fill;
    localparam int S = 2;

    logic clkin, reset_n, start, stop, dac_status;
    logic dac_reset, dac_play, fill_req, underrun, busy;

    msu_audio_fill_if #(.BUF_AW(11)) tb_if();

    msu_audio_fill #(.BUF_AW(11), .SYNC_STAGES(S)) dut (
        .clkin(clkin), .reset_n(reset_n), .start(start), .stop(stop),
        .dac_status(dac_status), .bus(tb_if), .dac_reset(dac_reset),
        .dac_play(dac_play), .fill_req(fill_req), .underrun(underrun), .busy(busy)
    );

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int fr_cnt = 0;
    int w0, f0;
    bit mon_en = 0;
    logic [10:0] exp_ptr;
    logic        pend = 0;
    logic [10:0] pend_a;
    logic [7:0]  pend_d;

    initial clkin = 0;
    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Buffer-port scoreboard: a byte taken in one cycle must appear on the
    // write port in the next, at the bench's own expected address.
    always @(negedge clkin) begin
        if (mon_en && reset_n) begin
            if (pend) begin
                chk("wr_we", tb_if.pgm_we_n, 0);
                chk("wr_addr", tb_if.pgm_address, pend_a);
                chk("wr_data", tb_if.pgm_data, pend_d);
            end else begin
                chk("no_wr", tb_if.pgm_we_n, 1);
            end
        end
        if (!tb_if.pgm_we_n) wr_cnt++;
        if (fill_req) fr_cnt++;
        pend   = reset_n && tb_if.in_valid && tb_if.in_ready;
        pend_a = exp_ptr;
        pend_d = tb_if.in_data;
        if (pend) exp_ptr = exp_ptr + 11'd1;
    end

    task automatic push_bytes(input int n, input bit gappy);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < n * 4 + 50) begin
            tb_if.in_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
            tb_if.in_data  = gappy ? 8'($urandom) : sent[7:0];
            @(negedge clkin);
            if (tb_if.in_valid && tb_if.in_ready) sent++;
            @(posedge clkin); #1;
            guard++;
        end
        tb_if.in_valid = 0;
        chk("push_cnt", sent, n);
    endtask

    task automatic pulse_start();
        start = 1;
        @(posedge clkin); #1;
        start = 0;
    endtask

    task automatic status_flip(input logic v);
        dac_status = v;
        repeat (S + 2) @(posedge clkin);
        #1;
    endtask

    task automatic settle();
        @(negedge clkin); #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_we"}, tb_if.pgm_we_n, 1);
        chk({tag, "_addr"}, tb_if.pgm_address, 0);
        chk({tag, "_data"}, tb_if.pgm_data, 0);
        chk({tag, "_rdy"}, tb_if.in_ready, 0);
        chk({tag, "_drst"}, dac_reset, 1);
        chk({tag, "_play"}, dac_play, 0);
        chk({tag, "_freq"}, fill_req, 0);
        chk({tag, "_und"}, underrun, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        reset_n = 0; start = 0; stop = 0; dac_status = 0;
        tb_if.in_valid = 0; tb_if.in_data = 0; exp_ptr = 0;
        #12;
        chk_reset("rst");
        @(posedge clkin); #1;
        reset_n = 1; mon_en = 1;
        @(posedge clkin); #1;

        // prime the full buffer
        exp_ptr = 0;
        pulse_start();
        chk("pr_busy", busy, 1);
        chk("pr_rdy", tb_if.in_ready, 1);
        chk("pr_drst0", dac_reset, 1);
        w0 = wr_cnt; f0 = fr_cnt;
        push_bytes(2048, 0);
        chk("pr_drst", dac_reset, 0);
        chk("pr_play", dac_play, 1);
        chk("pr_rdy_off", tb_if.in_ready, 0);
        settle();
        chk("pr_cnt", wr_cnt - w0, 2048);
        chk("pr_fr", fr_cnt - f0, 0);
        @(posedge clkin); #1;

        // normal refill of lower half, fill_req latency
        w0 = wr_cnt; f0 = fr_cnt;
        dac_status = 1;
        repeat (S) @(posedge clkin);
        #1;
        chk("fr_early", fill_req, 0);
        @(posedge clkin); #1;
        chk("fr_lat", fill_req, 1);
        push_bytes(1024, 0);
        chk("lo_rdy", tb_if.in_ready, 0);
        settle();
        chk("lo_cnt", wr_cnt - w0, 1024);
        chk("lo_fr", fr_cnt - f0, 1);
        @(posedge clkin); #1;

        // upper half with random gaps on in_valid
        w0 = wr_cnt;
        status_flip(0);
        push_bytes(1024, 1);
        chk("hi_rdy", tb_if.in_ready, 0);
        settle();
        chk("hi_cnt", wr_cnt - w0, 1024);
        chk("hi_und", underrun, 0);
        @(posedge clkin); #1;

        // underrun: DAC leaves the upper half after 500 lower-half bytes
        w0 = wr_cnt; f0 = fr_cnt;
        status_flip(1);
        push_bytes(500, 0);
        dac_status = 0;
        repeat (S + 2) @(posedge clkin);
        #1;
        exp_ptr = 11'd1024;
        chk("ur_flag", underrun, 1);
        chk("ur_fr", fr_cnt - f0, 2);
        chk("ur_rdy", tb_if.in_ready, 1);
        push_bytes(1024, 0);
        chk("ur_pw_rdy", tb_if.in_ready, 0);
        chk("ur_pw_busy", busy, 1);
        settle();
        chk("ur_cnt", wr_cnt - w0, 1524);
        @(posedge clkin); #1;

        // stop after 300 fill bytes, one more byte accepted with stop
        status_flip(1);
        w0 = wr_cnt;
        push_bytes(300, 0);
        tb_if.in_valid = 1; tb_if.in_data = 8'hA5; stop = 1;
        @(posedge clkin); #1;
        stop = 0;
        chk("sp_play", dac_play, 0);
        chk("sp_drst", dac_reset, 1);
        chk("sp_rdy", tb_if.in_ready, 0);
        chk("sp_busy", busy, 0);
        chk("sp_und", underrun, 1);
        repeat (3) @(posedge clkin);
        #1;
        tb_if.in_valid = 0;
        settle();
        chk("sp_cnt", wr_cnt - w0, 301);
        @(posedge clkin); #1;

        // restart: underrun cleared, writes from 0; start beats stop
        exp_ptr = 0;
        pulse_start();
        chk("rs_und", underrun, 0);
        w0 = wr_cnt;
        push_bytes(4, 0);
        exp_ptr = 0;
        start = 1; stop = 1;
        @(posedge clkin); #1;
        start = 0; stop = 0;
        chk("ss_busy", busy, 1);
        chk("ss_rdy", tb_if.in_ready, 1);
        settle();
        chk("rs_cnt", wr_cnt - w0, 4);
        @(posedge clkin); #1;
        push_bytes(2048, 0);
        chk("rp_play", dac_play, 1);

        // async reset in the middle of an upper-half fill
        status_flip(0);
        exp_ptr = 11'd1024;
        push_bytes(100, 0);
        tb_if.in_valid = 1;
        #2;
        chk("ar_pre_we", tb_if.pgm_we_n, 0);
        reset_n = 0;
        w0 = wr_cnt;
        #1;
        chk_reset("ar");
        @(posedge clkin); #3;
        reset_n = 1;
        repeat (20) @(posedge clkin);
        #1;
        tb_if.in_valid = 0;
        settle();
        chk("ar_cnt", wr_cnt - w0, 0);
        chk("ar_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
